ball_motion_unit: RTL and testbench
===================================

// Module: ball_motion_unit
// PURPOSE
//  Per-frame ball state for brick-smash. Sits directly downstream of the video sync generator:
//  consumes its hpos/vpos/vsync beam signals and produces the ball pixel (ball_gfx) for the RGB mixer.
//  Owns serve/move/miss sequencing. Bounces off screen edges and off collision flags from the playfield.
// PARAMETERS
//  H_DISPLAY    256  visible width, pixels
//  V_DISPLAY    240  visible height, lines
//  BALL_SIZE    4    ball edge length, pixels (square)
//  INIT_X       128  ball x after reset and after a miss
//  INIT_Y       128  ball y after reset and after a miss
//  SPEED        2    initial per-frame step, pixels, on each axis
//  MAX_SPEED    6    speed ceiling (used only with BALL_SPEEDUP_EN)
//  MISS_FRAMES  60   frames spent in MISS before returning to IDLE
// PORTS
//  clk       in   1  pixel clock
//  reset     in   1  asynchronous, active-low reset
//  hpos      in   9  beam x from sync generator
//  vpos      in   9  beam y from sync generator
//  vsync     in   1  vertical sync; its rising edge is the frame tick
//  serve     in   1  level; launches the ball from IDLE
//  hit_h     in   1  per-pixel flag: ball overlapped a vertical face (paddle side or brick side)
//  hit_v     in   1  per-pixel flag: ball overlapped a horizontal face (paddle top or brick top/bottom)
//  ball_gfx  out  1  beam is inside the ball square
//  ball_x    out  9  ball left edge
//  ball_y    out  9  ball top edge
//  miss      out  1  one-cycle pulse on entry to MISS
//  state     out  2  IDLE=0, MOVE=1, MISS=2
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE, ball_x=INIT_X, ball_y=INIT_Y, dx=+SPEED, dy=+SPEED,
//   miss=0, sticky flags=0, frame counter=0.
//  frame_tick = vsync & ~vsync_q. vsync_q is a 1-cycle register, so tick is the 1st cycle vsync is high.
//  ball_gfx = display-area-agnostic compare: (hpos-ball_x)<BALL_SIZE && (vpos-ball_y)<BALL_SIZE.
//   Comparison is unsigned 9-bit wrap. Combinational from registered positions, 0 latency.
//  Sticky hit_h_s/hit_v_s: set by hit_h/hit_v in any cycle; cleared on frame_tick.
//   A hit on the tick cycle itself sets the flag for the new frame and is not lost.
//  FSM, advancing only on frame_tick unless noted:
//   IDLE: ball parked at INIT. Advance to MOVE when serve=1 on the tick; dx=+SPEED, dy=+SPEED.
//   MOVE: first hit_h_s -> negate dx, hit_v_s -> negate dy (both may flip). Then step each axis:
//    left : dx<0 && ball_x<|dx|                    -> ball_x=0, dx=+|dx|
//    right: dx>0 && ball_x+dx>H_DISPLAY-BALL_SIZE  -> ball_x=H_DISPLAY-BALL_SIZE, dx=-|dx|
//    top  : dy<0 && ball_y<|dy|                    -> ball_y=0, dy=+|dy|
//    bottom: dy>0 && ball_y+dy>V_DISPLAY-BALL_SIZE -> MISS, miss=1 for one cycle, position frozen
//    otherwise ball_x+=dx, ball_y+=dy. Arithmetic is 10-bit internally; no wrap is permitted.
//   MISS: count MISS_FRAMES ticks. Then -> IDLE, position=INIT, counter=0, speed=SPEED.
//  serve is ignored outside IDLE. Bounce is combined with miss on the same tick; miss wins.
// CONFIGURATION
//  BALL_SPEEDUP_EN defined: 3-bit counter of paddle/brick bounces (hit_h_s|hit_v_s ticks in MOVE).
//   On every 8th bounce, |dx| and |dy| each increase by 1, saturating at MAX_SPEED.
//   Counter and speed return to their initial values on entry to IDLE.
//  BALL_SPEEDUP_EN undefined: speed fixed at SPEED; no counter logic is present.
// STRUCTURE
//  Shared package brick_pkg: H_DISPLAY/V_DISPLAY constants, ball_state_t enum (IDLE/MOVE/MISS).
//  One sub-module, frame_tick_gen: vsync rising-edge detector with the same clk/reset.
//  Used here and by the paddle block.
// TESTING (bench drives hpos/vpos/vsync from hvsync_generator; default params)
//  1 Reset low mid-MOVE -> ball_x=128, ball_y=128, state=IDLE immediately, before the next clk edge.
//  2 serve=1, 3 ticks -> state=MOVE, ball (134,134). ball_gfx=1 only at hpos 134..137, vpos 134..137.
//  3 ball_x=251, dx=+2, tick -> ball_x=252, dx=-2. Next tick -> ball_x=250.
//  4 hit_v pulse mid-frame with dy=+2 at y=100 -> at the tick, ball_y=98 and dy=-2.
//    The sticky flag is then clear.
//  5 ball_y=235, dy=+2, tick -> miss pulses 1 cycle, state=MISS.
//    After 60 ticks -> IDLE at (128,128). serve during MISS is ignored.
//  6 BALL_SPEEDUP_EN defined, 8 hit_h bounces -> |dx|=|dy|=3. Repeat -> speed saturates at 6.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared brick-smash constants and the ball sequencing state type.
package brick_pkg;

  localparam int H_DISPLAY   = 256;
  localparam int V_DISPLAY   = 240;
  localparam int BALL_SIZE   = 4;
  localparam int INIT_X      = 128;
  localparam int INIT_Y      = 128;
  localparam int SPEED       = 2;
  localparam int MAX_SPEED   = 6;
  localparam int MISS_FRAMES = 60;

  // Width of the per-axis speed magnitude (must hold MAX_SPEED).
  localparam int SPD_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    MISS = 2'd2
  } ball_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Vertical-sync rising-edge detector; the tick is high during the first
// cycle that vsync is seen high. Shared by the ball and paddle blocks.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic tick
);

  logic vsync_q_r;

  // Delay vsync by one cycle for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q_r <= 1'b0;
    end else begin
      vsync_q_r <= vsync;
    end
  end

  assign tick = vsync & ~vsync_q_r;

endmodule

// File: rtl/ball_motion_unit.sv
// Ball position, direction and serve/move/miss sequencing for brick-smash.
// Optional build macro BALL_SPEEDUP_EN: every 8th paddle/brick bounce raises
// the per-axis speed by one pixel per frame, capped at MAX_SPEED.
module ball_motion_unit
  import brick_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       vsync,
  input  logic       serve,
  input  logic       hit_h,
  input  logic       hit_v,
  output logic       ball_gfx,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y,
  output logic       miss,
  output logic [1:0] state
);

  localparam logic [9:0] X_MAX = 10'(H_DISPLAY - BALL_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_DISPLAY - BALL_SIZE);
  localparam int         CNT_W = $clog2(MISS_FRAMES);

  logic              tick_s;
  logic              hit_h_r;
  logic              hit_v_r;
  ball_state_t       state_r;
  logic [8:0]        ball_x_r;
  logic [8:0]        ball_y_r;
  logic              dx_neg_r;
  logic              dy_neg_r;
  logic              miss_r;
  logic [CNT_W-1:0]  miss_cnt_r;
  logic              miss_done_s;
  logic [SPD_W-1:0]  spd_s;

  logic [9:0]        mag_s;
  logic [9:0]        x_sum_s;
  logic [9:0]        y_sum_s;
  logic              dx_neg_flip_s;
  logic              dy_neg_flip_s;
  logic [8:0]        nx_s;
  logic [8:0]        ny_s;
  logic              ndx_neg_s;
  logic              ndy_neg_s;
  logic              bottom_s;

  logic [8:0]        h_off_s;
  logic [8:0]        v_off_s;

  frame_tick_gen u_frame_tick_gen (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .tick  (tick_s)
  );

  // Sticky collision flags: accumulate over a frame, restart on the tick
  // (a hit on the tick cycle itself belongs to the new frame).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_h_r <= 1'b0;
      hit_v_r <= 1'b0;
    end else if (tick_s) begin
      hit_h_r <= hit_h;
      hit_v_r <= hit_v;
    end else begin
      hit_h_r <= hit_h_r | hit_h;
      hit_v_r <= hit_v_r | hit_v;
    end
  end

  assign miss_done_s = (miss_cnt_r == CNT_W'(MISS_FRAMES - 1));

`ifdef BALL_SPEEDUP_EN
  logic [SPD_W-1:0] spd_r;
  logic [2:0]       bounce_cnt_r;
  logic             idle_entry_s;

  assign idle_entry_s = tick_s && (state_r == MISS) && miss_done_s;

  // Bounce counter and speed ramp; both restart when the ball is parked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spd_r        <= SPD_W'(SPEED);
      bounce_cnt_r <= 3'd0;
    end else if (idle_entry_s) begin
      spd_r        <= SPD_W'(SPEED);
      bounce_cnt_r <= 3'd0;
    end else if (tick_s && (state_r == MOVE) && (hit_h_r | hit_v_r)) begin
      bounce_cnt_r <= bounce_cnt_r + 3'd1;
      if ((bounce_cnt_r == 3'd7) && (spd_r < SPD_W'(MAX_SPEED))) begin
        spd_r <= spd_r + SPD_W'(1);
      end else begin
        spd_r <= spd_r;
      end
    end else begin
      spd_r        <= spd_r;
      bounce_cnt_r <= bounce_cnt_r;
    end
  end

  assign spd_s = spd_r;
`else
  assign spd_s = SPD_W'(SPEED);
`endif

  // Next-frame position and direction: apply collision flips, then wall rules.
  always_comb begin
    mag_s         = {{(10 - SPD_W){1'b0}}, spd_s};
    x_sum_s       = {1'b0, ball_x_r} + mag_s;
    y_sum_s       = {1'b0, ball_y_r} + mag_s;
    dx_neg_flip_s = dx_neg_r ^ hit_h_r;
    dy_neg_flip_s = dy_neg_r ^ hit_v_r;
    nx_s          = ball_x_r;
    ny_s          = ball_y_r;
    ndx_neg_s     = dx_neg_flip_s;
    ndy_neg_s     = dy_neg_flip_s;
    bottom_s      = 1'b0;

    if (dx_neg_flip_s) begin
      if ({1'b0, ball_x_r} < mag_s) begin
        nx_s      = 9'd0;
        ndx_neg_s = 1'b0;
      end else begin
        nx_s      = ball_x_r - mag_s[8:0];
        ndx_neg_s = 1'b1;
      end
    end else begin
      if (x_sum_s > X_MAX) begin
        nx_s      = X_MAX[8:0];
        ndx_neg_s = 1'b1;
      end else begin
        nx_s      = x_sum_s[8:0];
        ndx_neg_s = 1'b0;
      end
    end

    if (dy_neg_flip_s) begin
      if ({1'b0, ball_y_r} < mag_s) begin
        ny_s      = 9'd0;
        ndy_neg_s = 1'b0;
      end else begin
        ny_s      = ball_y_r - mag_s[8:0];
        ndy_neg_s = 1'b1;
      end
    end else begin
      if (y_sum_s > Y_MAX) begin
        bottom_s  = 1'b1;
        ny_s      = ball_y_r;
        ndy_neg_s = 1'b0;
      end else begin
        ny_s      = y_sum_s[8:0];
        ndy_neg_s = 1'b0;
      end
    end
  end

  // Serve/move/miss sequencer; advances only on the frame tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      ball_x_r   <= 9'(INIT_X);
      ball_y_r   <= 9'(INIT_Y);
      dx_neg_r   <= 1'b0;
      dy_neg_r   <= 1'b0;
      miss_r     <= 1'b0;
      miss_cnt_r <= '0;
    end else begin
      miss_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          IDLE: begin
            ball_x_r <= 9'(INIT_X);
            ball_y_r <= 9'(INIT_Y);
            dx_neg_r <= 1'b0;
            dy_neg_r <= 1'b0;
            if (serve) begin
              state_r <= MOVE;
            end else begin
              state_r <= IDLE;
            end
          end
          MOVE: begin
            if (bottom_s) begin
              state_r    <= MISS;
              miss_r     <= 1'b1;
              miss_cnt_r <= '0;
            end else begin
              ball_x_r <= nx_s;
              ball_y_r <= ny_s;
              dx_neg_r <= ndx_neg_s;
              dy_neg_r <= ndy_neg_s;
            end
          end
          MISS: begin
            if (miss_done_s) begin
              state_r    <= IDLE;
              ball_x_r   <= 9'(INIT_X);
              ball_y_r   <= 9'(INIT_Y);
              dx_neg_r   <= 1'b0;
              dy_neg_r   <= 1'b0;
              miss_cnt_r <= '0;
            end else begin
              miss_cnt_r <= miss_cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // Beam-in-ball test with 9-bit wrap, so the square is found anywhere.
  assign h_off_s  = hpos - ball_x_r;
  assign v_off_s  = vpos - ball_y_r;
  assign ball_gfx = (h_off_s < 9'(BALL_SIZE)) && (v_off_s < 9'(BALL_SIZE));

  assign ball_x = ball_x_r;
  assign ball_y = ball_y_r;
  assign miss   = miss_r;
  assign state  = state_r;

endmodule

// File: tb/tb_ball_motion_unit.sv
// Self-checking bench for ball_motion_unit: table-driven pixel checks,
// directed corner sequences and random frames against a frame-level model.
module tb_ball_motion_unit;

  localparam int XMAX  = 252;
  localparam int YMAX  = 236;
  localparam int IX    = 128;
  localparam int IY    = 128;
  localparam int SPD   = 2;
  localparam int MAXS  = 6;
  localparam int MISSF = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       vsync;
  logic       serve;
  logic       hit_h;
  logic       hit_v;
  logic       ball_gfx;
  logic [8:0] ball_x;
  logic [8:0] ball_y;
  logic       miss;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Frame-level reference model (signed velocities, plain integers).
  int m_state, m_x, m_y, m_vx, m_vy, m_cnt, m_bc, m_spd;
  bit m_h, m_v, m_miss;

  ball_motion_unit dut (
    .clk      (clk),
    .reset    (reset),
    .hpos     (hpos),
    .vpos     (vpos),
    .vsync    (vsync),
    .serve    (serve),
    .hit_h    (hit_h),
    .hit_v    (hit_v),
    .ball_gfx (ball_gfx),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .miss     (miss),
    .state    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [8:0] h;
    logic [8:0] v;
    logic       g;
  } gfx_vec_t;

  gfx_vec_t vecs[12];

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = IX; m_y = IY; m_vx = SPD; m_vy = SPD;
    m_cnt = 0; m_bc = 0; m_spd = SPD; m_h = 0; m_v = 0; m_miss = 0;
  endtask

  task automatic model_tick(input bit srv);
    bit bounced;
    int nx, ny;
    m_miss = 0;
    case (m_state)
      0: begin
        if (srv) begin
          m_state = 1; m_vx = m_spd; m_vy = m_spd;
        end
      end
      1: begin
        bounced = m_h | m_v;
        if (m_h) m_vx = -m_vx;
        if (m_v) m_vy = -m_vy;
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        if (m_vy > 0 && ny > YMAX) begin
          m_state = 2; m_cnt = 0; m_miss = 1;
        end else begin
          if (nx < 0) begin m_x = 0; m_vx = iabs(m_vx); end
          else if (nx > XMAX) begin m_x = XMAX; m_vx = -iabs(m_vx); end
          else m_x = nx;
          if (ny < 0) begin m_y = 0; m_vy = iabs(m_vy); end
          else m_y = ny;
        end
`ifdef BALL_SPEEDUP_EN
        if (bounced) begin
          m_bc++;
          if (m_bc == 8) begin
            m_bc = 0;
            if (m_spd < MAXS) m_spd++;
          end
        end
        m_vx = (m_vx < 0) ? -m_spd : m_spd;
        m_vy = (m_vy < 0) ? -m_spd : m_spd;
`endif
      end
      default: begin
        m_cnt++;
        if (m_cnt == MISSF) begin
          m_state = 0; m_x = IX; m_y = IY; m_cnt = 0; m_bc = 0; m_spd = SPD;
          m_vx = SPD; m_vy = SPD;
        end
      end
    endcase
  endtask

  // One short frame: two vsync-low cycles (hits fh/fv), then vsync held high
  // for two cycles (hits th/tv land on the tick cycle itself).
  task automatic do_frame(input bit srv, input bit fh = 0, input bit fv = 0,
                          input bit th = 0, input bit tv = 0);
    serve = srv; hit_h = fh; hit_v = fv; vsync = 1'b0;
    @(negedge clk);
    m_h = m_h | fh; m_v = m_v | fv;
    hit_h = 1'b0; hit_v = 1'b0;
    @(negedge clk);
    vsync = 1'b1; hit_h = th; hit_v = tv;
    @(negedge clk);
    model_tick(srv);
    m_h = th; m_v = tv;
    chk("frame_x", 32'(ball_x), 32'(m_x));
    chk("frame_y", 32'(ball_y), 32'(m_y));
    chk("frame_state", 32'(state), 32'(m_state));
    chk("frame_miss", 32'(miss), 32'(m_miss));
    hit_h = 1'b0; hit_v = 1'b0;
    @(negedge clk);
    chk("miss_one_cycle", 32'(miss), 32'd0);
    chk("held_vsync_no_tick", 32'(state), 32'(m_state));
    vsync = 1'b0;
  endtask

  initial begin
    int y0;
    bit fv;
    reset = 1'b0; vsync = 1'b0; serve = 1'b0; hit_h = 1'b0; hit_v = 1'b0;
    hpos = 9'd0; vpos = 9'd0;
    model_reset();

    vecs[0]  = '{9'd128, 9'd128, 1'b1};
    vecs[1]  = '{9'd131, 9'd131, 1'b1};
    vecs[2]  = '{9'd129, 9'd130, 1'b1};
    vecs[3]  = '{9'd132, 9'd128, 1'b0};
    vecs[4]  = '{9'd127, 9'd128, 1'b0};
    vecs[5]  = '{9'd128, 9'd132, 1'b0};
    vecs[6]  = '{9'd130, 9'd127, 1'b0};
    vecs[7]  = '{9'd0,   9'd0,   1'b0};
    vecs[8]  = '{9'd511, 9'd128, 1'b0};
    vecs[9]  = '{9'd131, 9'd127, 1'b0};
    vecs[10] = '{9'd127, 9'd131, 1'b0};
    vecs[11] = '{9'd130, 9'd129, 1'b1};

    // Reset state
    #12;
    chk("rst_x", 32'(ball_x), 32'd128);
    chk("rst_y", 32'(ball_y), 32'd128);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Pixel compare at the parked position
    for (int i = 0; i < 12; i++) begin
      hpos = vecs[i].h; vpos = vecs[i].v;
      #1;
      chk($sformatf("gfx_vec%0d", i), 32'(ball_gfx), 32'(vecs[i].g));
    end

    // Idle tick without serve stays parked
    do_frame(0);
    // Serve, then three moving frames -> (134,134)
    do_frame(1);
    do_frame(0); do_frame(0); do_frame(0);
    chk("serve_x", 32'(ball_x), 32'd134);
    chk("serve_y", 32'(ball_y), 32'd134);
    chk("serve_state", 32'(state), 32'd1);
    hpos = 9'd134; vpos = 9'd134; #1; chk("gfx_134", 32'(ball_gfx), 32'd1);
    hpos = 9'd137; vpos = 9'd137; #1; chk("gfx_137", 32'(ball_gfx), 32'd1);
    hpos = 9'd138; vpos = 9'd134; #1; chk("gfx_138", 32'(ball_gfx), 32'd0);
    hpos = 9'd133; vpos = 9'd137; #1; chk("gfx_133", 32'(ball_gfx), 32'd0);

    // Mid-frame hit_v with dy=+2 -> dy reverses at the tick; flag then clear
    do_frame(0, 0, 1);
    chk("hitv_y", 32'(ball_y), 32'd132);
    do_frame(0);
    chk("hitv_sticky_clear_y", 32'(ball_y), 32'd130);
    // Hit on the tick cycle counts for the following frame
    do_frame(0, 0, 0, 0, 1);
    chk("tickhit_y0", 32'(ball_y), 32'd128);
    do_frame(0);
    chk("tickhit_y1", 32'(ball_y), 32'd130);

    // Asynchronous reset mid-MOVE takes effect before the next clock edge
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_x", 32'(ball_x), 32'd128);
    chk("async_rst_y", 32'(ball_y), 32'd128);
    chk("async_rst_state", 32'(state), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Bottom miss, then MISS_FRAMES ticks back to IDLE with serve ignored
    do_frame(1);
    for (int i = 0; i < 100 && m_state == 1; i++) do_frame(0);
    chk("miss_state", 32'(state), 32'd2);
    for (int i = 1; i <= MISSF; i++) begin
      do_frame(1);
      if (i == MISSF - 1) chk("miss_hold", 32'(state), 32'd2);
    end
    chk("miss_back_idle", 32'(state), 32'd0);
    chk("miss_back_x", 32'(ball_x), 32'd128);
    chk("miss_back_y", 32'(ball_y), 32'd128);

    // Wall sweep: keep the ball off the bottom so it reaches left/right walls
    do_frame(1);
    for (int i = 0; i < 200; i++) begin
      fv = (m_state == 1) && (m_vy > 0) && (m_y >= 200);
      do_frame(0, 0, fv);
    end

`ifdef BALL_SPEEDUP_EN
    for (int i = 0; i < 4 && m_state != 0; i++) begin
      for (int k = 0; k < MISSF + 2 && m_state != 0; k++) do_frame(0);
    end
    do_frame(1);
    for (int i = 0; i < 8; i++) do_frame(0, 1, 1);
    y0 = int'(ball_y);
    do_frame(0);
    chk("speedup_step3", 32'(iabs(int'(ball_y) - y0)), 32'd3);
    for (int i = 0; i < 40; i++) do_frame(0, 1, 1);
    y0 = int'(ball_y);
    do_frame(0);
    chk("speedup_sat6", 32'(iabs(int'(ball_y) - y0)), 32'd6);
`endif

    // Random frames against the model
    for (int i = 0; i < 400; i++) begin
      do_frame($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
